// File: rtl/decode_stage.sv
// Y86-64 decode stage: F->D pipeline register, 15 x DATA_W register file with E/M
// write-back ports, source/destination selection and operand read with write-back bypass.
module decode_stage #(
    parameter int                DATA_W   = 64,
    parameter logic [DATA_W-1:0] RSP_INIT = 64'd1024
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [3:0]        f_icode_i,
    input  logic [3:0]        f_ifun_i,
    input  logic [3:0]        f_rA_i,
    input  logic [3:0]        f_rB_i,
    input  logic [DATA_W-1:0] f_valC_i,
    input  logic [DATA_W-1:0] f_valP_i,
    input  logic              f_instr_valid_i,
    input  logic              f_imem_error_i,
    input  logic              d_stall_i,
    input  logic              d_bubble_i,
    input  logic [3:0]        w_dstE_i,
    input  logic [DATA_W-1:0] w_valE_i,
    input  logic [3:0]        w_dstM_i,
    input  logic [DATA_W-1:0] w_valM_i,
    output logic [3:0]        d_icode_o,
    output logic [3:0]        d_ifun_o,
    output logic [DATA_W-1:0] d_valC_o,
    output logic [DATA_W-1:0] d_valA_o,
    output logic [DATA_W-1:0] d_valB_o,
    output logic [3:0]        d_srcA_o,
    output logic [3:0]        d_srcB_o,
    output logic [3:0]        d_dstE_o,
    output logic [3:0]        d_dstM_o,
    output logic [1:0]        d_stat_o
);

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;
    localparam logic [3:0] RNONE   = 4'hF;
    localparam logic [3:0] RRSP    = 4'h4;

    localparam logic [1:0] SAOK = 2'd0;
    localparam logic [1:0] SHLT = 2'd1;
    localparam logic [1:0] SADR = 2'd2;
    localparam logic [1:0] SINS = 2'd3;

    logic [3:0]        d_icode_r;
    logic [3:0]        d_ifun_r;
    logic [3:0]        d_rA_r;
    logic [3:0]        d_rB_r;
    logic [DATA_W-1:0] d_valC_r;
    logic [DATA_W-1:0] d_valP_r;
    logic [1:0]        d_stat_r;
    logic [1:0]        f_stat_s;

    logic [DATA_W-1:0] regs_r [15];

    logic [3:0]        src_a_s;
    logic [3:0]        src_b_s;
    logic [3:0]        dst_e_s;
    logic [3:0]        dst_m_s;
    logic [DATA_W-1:0] val_a_s;
    logic [DATA_W-1:0] val_b_s;

    // M is checked before E so a same-cycle read agrees with the write priority.
    function automatic logic [DATA_W-1:0] read_reg(
        input logic [3:0]        r,
        input logic [3:0]        dst_m,
        input logic [DATA_W-1:0] val_m,
        input logic [3:0]        dst_e,
        input logic [DATA_W-1:0] val_e,
        input logic [DATA_W-1:0] rf [15]
    );
        logic [DATA_W-1:0] v;
        v = '0;
        if (r == RNONE) begin
            v = '0;
        end else if (r == dst_m) begin
            v = val_m;
        end else if (r == dst_e) begin
            v = val_e;
        end else begin
            for (int i = 0; i < 15; i++) begin
                if (r == 4'(i)) begin
                    v = rf[i];
                end
            end
        end
        return v;
    endfunction

    // Status of the instruction arriving from fetch.
    always_comb begin
        f_stat_s = SAOK;
        if (f_imem_error_i) begin
            f_stat_s = SADR;
        end else if (!f_instr_valid_i) begin
            f_stat_s = SINS;
        end else if (f_icode_i == IHALT) begin
            f_stat_s = SHLT;
        end else begin
            f_stat_s = SAOK;
        end
    end

    // F->D pipeline register: stall holds, bubble inserts a NOP.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            d_icode_r <= INOP;
            d_ifun_r  <= 4'h0;
            d_rA_r    <= RNONE;
            d_rB_r    <= RNONE;
            d_valC_r  <= '0;
            d_valP_r  <= '0;
            d_stat_r  <= SAOK;
        end else if (d_stall_i) begin
            d_icode_r <= d_icode_r;
        end else if (d_bubble_i) begin
            d_icode_r <= INOP;
            d_ifun_r  <= 4'h0;
            d_rA_r    <= RNONE;
            d_rB_r    <= RNONE;
            d_valC_r  <= '0;
            d_valP_r  <= '0;
            d_stat_r  <= SAOK;
        end else begin
            d_icode_r <= f_icode_i;
            d_ifun_r  <= f_ifun_i;
            d_rA_r    <= f_rA_i;
            d_rB_r    <= f_rB_i;
            d_valC_r  <= f_valC_i;
            d_valP_r  <= f_valP_i;
            d_stat_r  <= f_stat_s;
        end
    end

    // Register file with two write ports; M overrides E on a shared destination.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 15; i++) begin
                regs_r[i] <= (i == 4) ? RSP_INIT : '0;
            end
        end else begin
            for (int i = 0; i < 15; i++) begin
                if (w_dstM_i == 4'(i)) begin
                    regs_r[i] <= w_valM_i;
                end else if (w_dstE_i == 4'(i)) begin
                    regs_r[i] <= w_valE_i;
                end
            end
        end
    end

    // Register id selection from the instruction held in D.
    always_comb begin
        src_a_s = RNONE;
        src_b_s = RNONE;
        dst_e_s = RNONE;
        dst_m_s = RNONE;
        case (d_icode_r)
            IRRMOVQ: begin src_a_s = d_rA_r; dst_e_s = d_rB_r; end
            IIRMOVQ: begin dst_e_s = d_rB_r; end
            IRMMOVQ: begin src_a_s = d_rA_r; src_b_s = d_rB_r; end
            IMRMOVQ: begin src_b_s = d_rB_r; dst_m_s = d_rA_r; end
            IOPQ:    begin src_a_s = d_rA_r; src_b_s = d_rB_r; dst_e_s = d_rB_r; end
            ICALL:   begin src_b_s = RRSP; dst_e_s = RRSP; end
            IRET:    begin src_a_s = RRSP; src_b_s = RRSP; dst_e_s = RRSP; end
            IPUSHQ:  begin src_a_s = d_rA_r; src_b_s = RRSP; dst_e_s = RRSP; end
            IPOPQ:   begin src_a_s = RRSP; src_b_s = RRSP; dst_e_s = RRSP; dst_m_s = d_rA_r; end
            default: begin
                src_a_s = RNONE;
                src_b_s = RNONE;
                dst_e_s = RNONE;
                dst_m_s = RNONE;
            end
        endcase
    end

    // Operand read; call and jump carry the fall-through PC in valA.
    always_comb begin
        val_a_s = '0;
        val_b_s = read_reg(src_b_s, w_dstM_i, w_valM_i, w_dstE_i, w_valE_i, regs_r);
        if (d_icode_r == ICALL || d_icode_r == IJXX) begin
            val_a_s = d_valP_r;
        end else begin
            val_a_s = read_reg(src_a_s, w_dstM_i, w_valM_i, w_dstE_i, w_valE_i, regs_r);
        end
    end

    assign d_icode_o = d_icode_r;
    assign d_ifun_o  = d_ifun_r;
    assign d_valC_o  = d_valC_r;
    assign d_valA_o  = val_a_s;
    assign d_valB_o  = val_b_s;
    assign d_srcA_o  = src_a_s;
    assign d_srcB_o  = src_b_s;
    assign d_dstE_o  = dst_e_s;
    assign d_dstM_o  = dst_m_s;
    assign d_stat_o  = d_stat_r;

endmodule
